// File: rtl/scale_mux_pkg.sv
// ---------------------------------------------------------------------------
// scale_mux_pkg
// Shared definitions for the scale_mux leaf cell and its register stage.
//   SCALE_MUX_DEFAULT_WIDTH : default data width of the mux buses.
//   scale_mux_sel_e         : symbolic encoding of the select line.
// ---------------------------------------------------------------------------
package scale_mux_pkg;

    localparam int SCALE_MUX_DEFAULT_WIDTH = 16;

    typedef enum logic {
        SEL_B = 1'b0,
        SEL_A = 1'b1
    } scale_mux_sel_e;

endpackage : scale_mux_pkg

// File: rtl/scale_mux_reg.sv
// ---------------------------------------------------------------------------
// scale_mux_reg
// One-cycle retiming stage for a data bus plus its select flag, with
// synchronous active-high reset. Reusable to retime any bus.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (clears data and select)
//   data_i : bus to be registered (WIDTH bits)
//   sel_i  : select flag travelling alongside the bus
//   data_o : registered bus, one cycle after data_i
//   sel_o  : registered select flag, aligned with data_o
// ---------------------------------------------------------------------------
module scale_mux_reg
    import scale_mux_pkg::*;
#(
    parameter int WIDTH = SCALE_MUX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] data_o,
    output logic             sel_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    scale_mux_sel_e   sel_q;
    scale_mux_sel_e   sel_d;

    always_comb begin
        data_d = data_i;
        sel_d  = scale_mux_sel_e'(sel_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= SEL_B;
        end else begin
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end

    assign data_o = data_q;
    assign sel_o  = logic'(sel_q);

endmodule : scale_mux_reg

// File: rtl/scale_mux.sv
// ---------------------------------------------------------------------------
// scale_mux
// Parameterised-width 2:1 bus multiplexer with a combinational output and
// a registered copy for pipelined consumers.
// Ports:
//   clk   : rising-edge clock (registered path only)
//   rst   : synchronous active-high reset (registered path only)
//   in_a  : data source A (WIDTH bits)
//   in_b  : data source B (WIDTH bits)
//   sel_a : 1 selects in_a, 0 selects in_b
//   out   : combinational selected data, independent of clk/rst
//   out_q : selected data registered at the previous rising edge
//   sel_q : sel_a registered at the previous rising edge, aligned with out_q
// ---------------------------------------------------------------------------
module scale_mux
    import scale_mux_pkg::*;
#(
    parameter int WIDTH = SCALE_MUX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             sel_a,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("scale_mux: WIDTH must be >= 1");
        end
    endgenerate

    // The conditional operator is kept deliberately: an unknown select
    // merges the two sources bitwise in simulation instead of forcing
    // the whole bus to X.
    assign out = sel_a ? in_a : in_b;

    scale_mux_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk    (clk),
        .rst    (rst),
        .data_i (out),
        .sel_i  (sel_a),
        .data_o (out_q),
        .sel_o  (sel_q)
    );

endmodule : scale_mux

// File: tb/tb_scale_mux.sv
module tb_scale_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic [15:0] in_a, in_b, out16, out_q16;
    logic        sel_a, sel_q16;

    // WIDTH=1 instance
    logic [0:0]  a1, b1, o1, oq1;
    logic        s1, sq1;

    // WIDTH=33 instance
    logic [32:0] a33, b33, o33, oq33;
    logic        s33, sq33;

    scale_mux #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .sel_a(sel_a),
        .out(out16), .out_q(out_q16), .sel_q(sel_q16)
    );

    scale_mux #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .in_a(a1), .in_b(b1), .sel_a(s1),
        .out(o1), .out_q(oq1), .sel_q(sq1)
    );

    scale_mux #(.WIDTH(33)) dut_w33 (
        .clk(clk), .rst(rst), .in_a(a33), .in_b(b33), .sel_a(s33),
        .out(o33), .out_q(oq33), .sel_q(sq33)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sel;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    logic [15:0] prev_exp;
    logic [15:0] cur_exp;
    logic        prev_sel;

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{16'h0000, 16'h0000, 1'b1, 16'h0000};
        vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
        vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b0, 16'h0000};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF};
        vecs[8] = '{16'hA5C3, 16'h1234, 1'b1, 16'hA5C3};
        vecs[9] = '{16'hA5C3, 16'h1234, 1'b0, 16'h1234};

        in_a = '0; in_b = '0; sel_a = 1'b0;
        a1 = '0; b1 = '0; s1 = 1'b0;
        a33 = '0; b33 = '0; s33 = 1'b0;

        // Combinational table, applied while reset is held: out must not care.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_a = vecs[i].a; in_b = vecs[i].b; sel_a = vecs[i].sel;
            #1;
            check($sformatf("comb16[%0d]", i), 64'(out16), 64'(vecs[i].exp));
        end

        // Width sweep: corner rows with all-zero / all-one fills.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1  = (vecs[i].a != 0) ? '1 : '0;
            b1  = (vecs[i].b != 0) ? '1 : '0;
            s1  = vecs[i].sel;
            a33 = (vecs[i].a != 0) ? '1 : '0;
            b33 = (vecs[i].b != 0) ? '1 : '0;
            s33 = vecs[i].sel;
            #1;
            check($sformatf("comb_w1[%0d]", i), 64'(o1),
                  (vecs[i].exp != 0) ? 64'h1 : 64'h0);
            check($sformatf("comb_w33[%0d]", i), 64'(o33),
                  (vecs[i].exp != 0) ? 64'h1_FFFF_FFFF : 64'h0);
        end

        // Reset: hold rst with nonzero data across 2 edges.
        @(negedge clk);
        rst = 1'b1; in_a = 16'h1234; sel_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_q", 64'(out_q16), 64'h0);
        check("rst_sel_q", 64'(sel_q16), 64'h0);
        check("rst_out_comb", 64'(out16), 64'h1234);

        // Release and load BEEF: visible one edge later, not before.
        @(negedge clk);
        rst = 1'b0; in_a = 16'hBEEF; in_b = 16'h0000; sel_a = 1'b1;
        #1;
        check("load_not_before", 64'(out_q16), 64'h0);
        @(posedge clk); #1;
        check("load_out_q", 64'(out_q16), 64'hBEEF);
        check("load_sel_q", 64'(sel_q16), 64'h1);

        // Mid-stream reset: asserting between edges must not clear out_q.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_between_edges", 64'(out_q16), 64'hBEEF);
        check("midrst_out_comb", 64'(out16), 64'hBEEF);
        @(posedge clk); #1;
        check("midrst_out_q", 64'(out_q16), 64'h0);
        check("midrst_sel_q", 64'(sel_q16), 64'h0);
        check("midrst_out_comb2", 64'(out16), 64'hBEEF);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_reload", 64'(out_q16), 64'hBEEF);

        // Per-cycle toggle: out_q lags out by exactly one cycle.
        prev_exp = 16'hBEEF;
        prev_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_a = 16'hFFFF; in_b = 16'h0000; sel_a = i[0];
            cur_exp = i[0] ? 16'hFFFF : 16'h0000;
            #1;
            check($sformatf("tog_comb[%0d]", i), 64'(out16), 64'(cur_exp));
            check($sformatf("tog_lag[%0d]", i), 64'(out_q16), 64'(prev_exp));
            @(posedge clk); #1;
            check($sformatf("tog_out_q[%0d]", i), 64'(out_q16), 64'(cur_exp));
            check($sformatf("tog_sel_q[%0d]", i), 64'(sel_q16), 64'(i[0]));
            prev_exp = cur_exp;
            prev_sel = i[0];
        end

        // Registered path on the odd widths too.
        @(negedge clk);
        a33 = '1; b33 = '0; s33 = 1'b1; a1 = 1'b1; b1 = 1'b0; s1 = 1'b0;
        @(posedge clk); #1;
        check("w33_out_q", 64'(oq33), 64'h1_FFFF_FFFF);
        check("w33_sel_q", 64'(sq33), 64'h1);
        check("w1_out_q", 64'(oq1), 64'h0);
        check("w1_sel_q", 64'(sq1), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_scale_mux
